// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, FSM states and opcode helpers shared by the execute ALU and the control decoder.
package alu_pkg;

    typedef enum logic [5:0] {
        ALU_AND     = 6'b000000,
        ALU_OR      = 6'b000001,
        ALU_ADD     = 6'b000010,
        ALU_SUB     = 6'b000110,
        ALU_XOR     = 6'b000111,
        ALU_SLTU    = 6'b001001,
        ALU_SLT     = 6'b001010,
        ALU_SLL     = 6'b001011,
        ALU_SRL     = 6'b001100,
        ALU_SRA     = 6'b001101,
        ALU_MUL     = 6'b010000,
        ALU_MULH    = 6'b010001,
        ALU_MULHSU  = 6'b010010,
        ALU_MULHU   = 6'b010011,
        ALU_ILLEGAL = 6'b111111
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;

    function automatic logic is_mul_op(input logic [5:0] op);
        return op[5:2] == 4'b0100;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand-in / result-out handshake bundle of the execute ALU.
interface alu_exec_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       alu_operation;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, alu_operation, rs1, rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, alu_operation, rs1, rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal
    );
endinterface

// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: shift-add multiplier on operand magnitudes, sign restored on the product.
// ALU_MUL_EARLY_OUT_EN stops once the remaining multiplier magnitude is zero.
module alu_seq_multiplier import alu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic              a_signed_i,
    input  logic              b_signed_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              done_o,
    output logic              skip_o,
    output logic [2*XLEN-1:0] product_o
);
    localparam int CW = $clog2(XLEN);

    logic              run_q, neg_q;
    logic [2*XLEN-1:0] mcand_q, acc_q, acc_d;
    logic [XLEN-1:0]   mplier_q, a_mag, b_mag;
    logic [CW-1:0]     cnt_q;
    logic              a_neg, b_neg;

    assign a_neg = a_signed_i && a_i[XLEN-1];
    assign b_neg = b_signed_i && b_i[XLEN-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;
    // acc_d settles to acc_q once the run ends, so the product stays stable while held
    assign acc_d     = acc_q + ((run_q && mplier_q[0]) ? mcand_q : '0);
    assign product_o = neg_q ? -acc_d : acc_d;

`ifdef ALU_MUL_EARLY_OUT_EN
    assign done_o = run_q && (cnt_q == CW'(XLEN-1) || mplier_q[XLEN-1:1] == '0);
    assign skip_o = b_i == '0;
`else
    assign done_o = run_q && cnt_q == CW'(XLEN-1);
    assign skip_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            neg_q    <= a_neg ^ b_neg;
            mcand_q  <= {{XLEN{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (run_q) begin
            run_q    <= !done_o && !kill_i;
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU, one-cycle integer ops plus iterative MUL family behind a one-deep output register.
// ALU_MUL_EARLY_OUT_EN enables early termination of multiplies.
module alu_exec_unit import alu_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    output logic            busy,
    alu_exec_unit_if.slave  io
);
    localparam int SW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d, out_illegal_q, out_illegal_d;
    logic [XLEN-1:0]   out_result_q, out_result_d, alu_res, mul_res;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d, mtag_q, mtag_d;
    logic [1:0]        mop_q, mop_d;
    logic [5:0]        op;
    logic [SW-1:0]     shamt;
    logic              alu_ill, is_mul, accept, free, mul_done, mul_skip, mul_start;
    logic [2*XLEN-1:0] product;

    assign op          = io.alu_operation;
    assign shamt       = io.rs2[SW-1:0];
    assign is_mul      = is_mul_op(op);
    assign free        = !out_valid_q || io.out_ready;
    assign io.in_ready = state_q == IDLE && free;
    assign accept      = io.in_valid && io.in_ready && !flush;
    assign mul_start   = accept && is_mul && !mul_skip;
    assign mul_res     = mop_q == 2'b00 ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    assign busy        = state_q == MUL;

    assign io.out_valid   = out_valid_q;
    assign io.out_result  = out_result_q;
    assign io.out_tag     = out_tag_q;
    assign io.out_illegal = out_illegal_q;

    alu_seq_multiplier #(.XLEN(XLEN)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start_i    (mul_start),
        .kill_i     (flush),
        .a_signed_i (op == ALU_MULH || op == ALU_MULHSU),
        .b_signed_i (op == ALU_MULH),
        .a_i        (io.rs1),
        .b_i        (io.rs2),
        .done_o     (mul_done),
        .skip_o     (mul_skip),
        .product_o  (product)
    );

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            ALU_AND:  alu_res = io.rs1 & io.rs2;
            ALU_OR:   alu_res = io.rs1 | io.rs2;
            ALU_ADD:  alu_res = io.rs1 + io.rs2;
            ALU_SUB:  alu_res = io.rs1 - io.rs2;
            ALU_XOR:  alu_res = io.rs1 ^ io.rs2;
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, io.rs1 < io.rs2};
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(io.rs1) < $signed(io.rs2)};
            ALU_SLL:  alu_res = io.rs1 << shamt;
            ALU_SRL:  alu_res = io.rs1 >> shamt;
            ALU_SRA:  alu_res = $signed(io.rs1) >>> shamt;
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = '0;
            default:  alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q && !io.out_ready;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        out_illegal_d = out_illegal_q;
        mop_d         = mop_q;
        mtag_d        = mtag_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    if (mul_start) begin
                        state_d = MUL;
                        mop_d   = op[1:0];
                        mtag_d  = io.in_tag;
                    end else begin
                        out_valid_d   = 1'b1;
                        out_result_d  = is_mul ? '0 : alu_res;
                        out_tag_d     = io.in_tag;
                        out_illegal_d = alu_ill;
                    end
                end
                MUL, HOLD: if (state_q == HOLD || mul_done) begin
                    // product stays valid in the multiplier until the output register frees up
                    state_d       = free ? IDLE : HOLD;
                    out_valid_d   = free ? 1'b1 : out_valid_d;
                    out_result_d  = free ? mul_res : out_result_q;
                    out_tag_d     = free ? mtag_q : out_tag_q;
                    out_illegal_d = free ? 1'b0 : out_illegal_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
            mop_q         <= '0;
            mtag_q        <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_tag_q     <= out_tag_d;
            out_illegal_q <= out_illegal_d;
            mop_q         <= mop_d;
            mtag_q        <= mtag_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic busy;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(32), .TAG_W(5)) bus ();

    alu_exec_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .busy  (busy),
        .io    (bus.slave)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t alu_v [10];
    vec_t mul_v [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        bus.in_valid      = 1'b1;
        bus.alu_operation = op;
        bus.rs1           = a;
        bus.rs2           = b;
        bus.in_tag        = t;
    endtask

    function automatic int exp_lat(input logic [5:0] op, input logic [31:0] b);
`ifdef ALU_MUL_EARLY_OUT_EN
        logic [31:0] m;
        int k;
        m = (op == 6'b010001 && b[31]) ? -b : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        return 1 + k;
`else
        return 33;
`endif
    endfunction

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alu_operation = '0;
        bus.rs1 = '0; bus.rs2 = '0; bus.in_tag = '0;
        step(); step();
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_result !== 32'h0 || bus.out_tag !== 5'h0 || bus.out_illegal !== 1'b0) begin
            failed++;
            $display("FAIL reset_outputs: valid=%b busy=%b result=%h tag=%h ill=%b, want all 0",
                     bus.out_valid, busy, bus.out_result, bus.out_tag, bus.out_illegal);
        end
        rst = 1'b0;
        step();
        tests++;
        if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        offer(6'b000010, 32'h7FFFFFFF, 32'h1, 5'd3);
        step();
        offer(6'b000110, 32'd5, 32'd7, 5'd4);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h80000000 || bus.out_tag !== 5'd3) begin
            failed++;
            $display("FAIL add_wrap: valid=%b result=%h tag=%0d want 1 80000000 3", bus.out_valid, bus.out_result, bus.out_tag);
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFFFFFE || bus.out_tag !== 5'd4) begin
            failed++;
            $display("FAIL sub_b2b: valid=%b result=%h tag=%0d want 1 fffffffe 4", bus.out_valid, bus.out_result, bus.out_tag);
        end
        step();
        tests++;
        if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL b2b_drain: valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_alu_ops();
        alu_v = '{
            '{6'b001101, 32'h80000000, 32'h24, 32'hF8000000},
            '{6'b001100, 32'h80000000, 32'h24, 32'h08000000},
            '{6'b001010, 32'hFFFFFFFF, 32'h1, 32'h1},
            '{6'b001001, 32'hFFFFFFFF, 32'h1, 32'h0},
            '{6'b001011, 32'h1, 32'h3F, 32'h80000000},
            '{6'b000000, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F},
            '{6'b000001, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF},
            '{6'b000111, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0},
            '{6'b001010, 32'h1, 32'hFFFFFFFF, 32'h0},
            '{6'b001001, 32'h1, 32'hFFFFFFFF, 32'h1}
        };
        bus.out_ready = 1'b1;
        foreach (alu_v[i]) begin
            offer(alu_v[i].op, alu_v[i].a, alu_v[i].b, 5'(i));
            step();
            bus.in_valid = 1'b0;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== alu_v[i].r || bus.out_illegal !== 1'b0) begin
                failed++;
                $display("FAIL alu_op[%0d] op=%b: valid=%b result=%h ill=%b want 1 %h 0",
                         i, alu_v[i].op, bus.out_valid, bus.out_result, bus.out_illegal, alu_v[i].r);
            end
        end
        step();
    endtask

    task automatic test_mul();
        int n, bc, bad;
        mul_v = '{
            '{6'b010001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
            '{6'b010011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
            '{6'b010010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{6'b010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001}
        };
        bus.out_ready = 1'b1;
        foreach (mul_v[i]) begin
            offer(mul_v[i].op, mul_v[i].a, mul_v[i].b, 5'(20 + i));
            step();
            bus.in_valid = 1'b0;
            n = 1; bc = 0; bad = 0;
            while (!bus.out_valid && n < 60) begin
                if (bus.in_ready !== 1'b0) bad++;
                if (busy) bc++;
                step();
                n++;
            end
            tests++;
            if (n != exp_lat(mul_v[i].op, mul_v[i].b)) begin
                failed++;
                $display("FAIL mul_latency[%0d]: got %0d want %0d", i, n, exp_lat(mul_v[i].op, mul_v[i].b));
            end
            tests++;
            if (bad != 0 || bc != exp_lat(mul_v[i].op, mul_v[i].b) - 1) begin
                failed++;
                $display("FAIL mul_busy_ready[%0d]: in_ready high %0d cycles, busy %0d cycles, want 0 and %0d",
                         i, bad, bc, exp_lat(mul_v[i].op, mul_v[i].b) - 1);
            end
            tests++;
            if (bus.out_result !== mul_v[i].r || bus.out_tag !== 5'(20 + i) || bus.out_illegal !== 1'b0) begin
                failed++;
                $display("FAIL mul_result[%0d]: result=%h tag=%0d ill=%b want %h %0d 0",
                         i, bus.out_result, bus.out_tag, bus.out_illegal, mul_v[i].r, 20 + i);
            end
            step();
        end
    endtask

    task automatic test_hold();
        int n, bad;
        bus.out_ready = 1'b0;
        offer(6'b010000, 32'd7, 32'd6, 5'd9);
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 60) begin step(); n++; end
        tests++;
        if (n != exp_lat(6'b010000, 32'd6)) begin
            failed++;
            $display("FAIL hold_latency: got %0d want %0d", n, exp_lat(6'b010000, 32'd6));
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd42 || bus.out_tag !== 5'd9 || bus.in_ready !== 1'b0) bad++;
            step();
        end
        tests++;
        if (bad != 0) begin failed++; $display("FAIL hold_stable: %0d unstable cycles, want 0", bad); end
        bus.out_ready = 1'b1;
        step();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL hold_drain: valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [3];
        ops = '{6'b110000, 6'b111111, 6'b000011};
        bus.out_ready = 1'b1;
        foreach (ops[i]) begin
            offer(ops[i], 32'hDEADBEEF, 32'h12345678, 5'(17 + i));
            step();
            bus.in_valid = 1'b0;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'h0 || bus.out_tag !== 5'(17 + i)) begin
                failed++;
                $display("FAIL illegal[%b]: valid=%b ill=%b result=%h tag=%0d want 1 1 0 %0d",
                         ops[i], bus.out_valid, bus.out_illegal, bus.out_result, bus.out_tag, 17 + i);
            end
        end
        step();
    endtask

    task automatic test_flush();
        int seen;
        bus.out_ready = 1'b1;
        offer(6'b010011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failed++;
            $display("FAIL flush_mul: in_ready=%b busy=%b valid=%b want 1 0 0", bus.in_ready, busy, bus.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin if (bus.out_valid) seen++; step(); end
        tests++;
        if (seen != 0) begin failed++; $display("FAIL flush_no_output: valid seen %0d cycles want 0", seen); end
        offer(6'b000010, 32'd1, 32'd2, 5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL flush_discard: valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_async_reset();
        int seen;
        bus.out_ready = 1'b1;
        offer(6'b000010, 32'h11111111, 32'h22222222, 5'd7);
        step();
        offer(6'b010011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_result !== 32'h0 || bus.out_tag !== 5'h0 || bus.out_illegal !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: valid=%b busy=%b result=%h tag=%h ill=%b want all 0",
                     bus.out_valid, busy, bus.out_result, bus.out_tag, bus.out_illegal);
        end
        #1 rst = 1'b0;
        step();
        seen = 0;
        for (int i = 0; i < 40; i++) begin if (bus.out_valid || busy) seen++; step(); end
        tests++;
        if (seen != 0 || bus.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_abort: active cycles %0d in_ready=%b want 0 1", seen, bus.in_ready);
        end
    endtask

`ifdef ALU_MUL_EARLY_OUT_EN
    task automatic test_early_out();
        int n;
        bus.out_ready = 1'b1;
        offer(6'b010000, 32'd3, 32'd2, 5'd10);
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 60) begin step(); n++; end
        tests++;
        if (n != 3 || bus.out_result !== 32'd6) begin
            failed++;
            $display("FAIL early_3x2: latency=%0d result=%h want 3 6", n, bus.out_result);
        end
        step();
        offer(6'b010000, 32'd3, 32'd0, 5'd11);
        step();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL early_3x0: valid=%b result=%h busy=%b want 1 0 0", bus.out_valid, bus.out_result, busy);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_alu_ops();
        test_mul();
        test_hold();
        test_illegal();
        test_flush();
`ifdef ALU_MUL_EARLY_OUT_EN
        test_early_out();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
